// File: rtl/xdata_ctrl.sv
// ============================================================================
//  Module      : xdata_ctrl
//  Description : Host-side data/control bridge. Decodes the host bus into
//                one-hot memory strobes or a small control register space
//                (CTRL, STATUS, RUN_COUNT). A start command freezes the live
//                configuration into config_shadow, issues a one-cycle run
//                pulse to the functional units and waits for every done
//                flag before returning to idle.
//                Optional feature macro: XDATA_CTRL_REPEAT_EN
//                (defined: RUN_COUNT+1 back-to-back runs per start;
//                 undefined: one run per start, RUN_COUNT reads 0).
//                Timing: the write that starts the engine is sampled on
//                edge E0; LOAD follows, run is high in the cycle after
//                E1; consecutive runs of a repeat sequence are three cycles
//                apart.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xdata_ctrl #(
    parameter int DATA_W     = 32,
    parameter int N_MEM      = 4,
    parameter int N_MEM_W    = 2,
    parameter int MEM_ADDR_W = 10,
    parameter int CONF_W     = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic                          we,
    input  logic [N_MEM_W+MEM_ADDR_W:0]   addr,
    input  logic [DATA_W-1:0]             rdata,
    output logic [DATA_W-1:0]             wdata,
    output logic [N_MEM-1:0]              mem_valid,
    output logic [MEM_ADDR_W-1:0]         mem_addr,
    input  logic [N_MEM*DATA_W-1:0]       mem_rdata,
    input  logic [2*N_MEM-1:0]            fu_done,
    input  logic [CONF_W-1:0]             config_bus,
    output logic [CONF_W-1:0]             config_shadow,
    output logic                          run,
    output logic                          busy
);

    localparam int c_ADDR_MSB = N_MEM_W + MEM_ADDR_W;

    // Control register indices (addr[1:0] inside control space)
    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_RCOUNT = 2'd2;

    // Post-FIRE window during which done flags are not trusted
    localparam logic [1:0] c_GUARD_LOAD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FIRE = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   w_ctrl_space;
    logic [N_MEM_W-1:0]     w_mem_sel;
    logic [1:0]             w_reg;
    logic                   w_rd;
    logic                   w_ctrl_wr;
    logic                   w_stat_wr;
    logic                   w_rc_wr;
    logic                   w_start;
    logic                   w_abort;
    logic                   w_wait_done;
    logic                   w_more;
    logic [15:0]            w_run_count;

    logic [1:0]             r_guard;
    logic                   r_done;
    logic                   r_err;

    logic                   r_rd_mem;
    logic [N_MEM_W-1:0]     r_mem_sel;
    logic [DATA_W-1:0]      r_hold;
    logic [DATA_W-1:0]      w_mem_slice;
    logic [DATA_W-1:0]      w_ctrl_rdata;

    logic                   w_unused_bits;

    // ------------------------------------------------------------------
    // Host address decode
    // ------------------------------------------------------------------
    assign w_ctrl_space = addr[c_ADDR_MSB];
    assign w_mem_sel    = addr[MEM_ADDR_W +: N_MEM_W];
    assign w_reg        = addr[1:0];
    assign mem_addr     = addr[MEM_ADDR_W-1:0];

    assign w_rd      = valid & ~we;
    assign w_ctrl_wr = valid & we & w_ctrl_space & (w_reg == c_REG_CTRL);
    assign w_stat_wr = valid & we & w_ctrl_space & (w_reg == c_REG_STATUS);
    assign w_rc_wr   = valid & we & w_ctrl_space & (w_reg == c_REG_RCOUNT);

    // Abort dominates a simultaneous start request
    assign w_abort = w_ctrl_wr & rdata[1];
    assign w_start = w_ctrl_wr & rdata[0] & ~rdata[1];

    // Only rdata[2:0] (and RUN_COUNT bits) carry meaning here
    assign w_unused_bits = ^rdata;

    genvar gj;
    generate
        for (gj = 0; gj < N_MEM; gj++) begin : g_mem_valid
            assign mem_valid[gj] = valid & ~w_ctrl_space &
                                   (w_mem_sel == N_MEM_W'(gj));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Optional repeat feature: RUN_COUNT register and remaining count
    // ------------------------------------------------------------------
`ifdef XDATA_CTRL_REPEAT_EN
    logic [15:0] r_run_count;
    logic [15:0] r_remain;

    // RUN_COUNT is writable only while the engine is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_count <= 16'd0;
        end else if (w_rc_wr && (r_state == S_IDLE)) begin
            r_run_count <= rdata[15:0];
        end
    end

    // Remaining-run copy: taken in LOAD, consumed on each completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remain <= 16'd0;
        end else if (r_state == S_LOAD) begin
            r_remain <= r_run_count;
        end else if (w_wait_done && w_more && !w_abort) begin
            r_remain <= r_remain - 16'd1;
        end
    end

    assign w_more      = (r_remain != 16'd0);
    assign w_run_count = r_run_count;
`else
    logic w_unused_rc;
    assign w_unused_rc = w_rc_wr;
    assign w_more      = 1'b0;
    assign w_run_count = 16'd0;
`endif

    // ------------------------------------------------------------------
    // Engine FSM
    // ------------------------------------------------------------------
    assign w_wait_done = (r_state == S_WAIT) && (r_guard == 2'd0) && (&fu_done);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; an abort overrides every transition
    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) w_state_next = S_LOAD;
                S_LOAD: w_state_next = S_FIRE;
                S_FIRE: w_state_next = S_WAIT;
                S_WAIT: begin
                    if (w_wait_done) begin
                        w_state_next = w_more ? S_FIRE : S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Guard counter: loaded on entry to FIRE, then counts down to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_guard <= 2'd0;
        end else if (w_state_next == S_FIRE) begin
            r_guard <= c_GUARD_LOAD;
        end else if (r_guard != 2'd0) begin
            r_guard <= r_guard - 2'd1;
        end
    end

    // Configuration snapshot, updated only while in LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            config_shadow <= '0;
        end else if (r_state == S_LOAD) begin
            config_shadow <= config_bus;
        end
    end

    // Done flag: cleared by an accepted start or abort, set on final completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else if (w_abort || (w_start && (r_state == S_IDLE))) begin
            r_done <= 1'b0;
        end else if (w_wait_done && !w_more) begin
            r_done <= 1'b1;
        end
    end

    // Sticky error on start-while-busy, cleared by STATUS bit2 write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start && (r_state != S_IDLE)) begin
            r_err <= 1'b1;
        end else if (w_stat_wr && rdata[2]) begin
            r_err <= 1'b0;
        end
    end

    assign run  = (r_state == S_FIRE);
    assign busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Host read path
    // ------------------------------------------------------------------

    // Select the data lane of the memory addressed by the previous read
    always_comb begin
        w_mem_slice = '0;
        for (int j = 0; j < N_MEM; j++) begin
            if (r_mem_sel == N_MEM_W'(j)) begin
                w_mem_slice = mem_rdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // Control-space read data
    always_comb begin
        w_ctrl_rdata = '0;
        case (w_reg)
            c_REG_STATUS: w_ctrl_rdata = DATA_W'({r_err, r_done, busy});
            c_REG_RCOUNT: w_ctrl_rdata = DATA_W'(w_run_count);
            default:      w_ctrl_rdata = '0;
        endcase
    end

    // Memories answer one cycle after the strobe; the answer is shown live
    // in that cycle and captured into r_hold so it persists afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_mem  <= 1'b0;
            r_mem_sel <= '0;
            r_hold    <= '0;
        end else begin
            if (r_rd_mem) begin
                r_hold <= w_mem_slice;
            end
            if (w_rd) begin
                r_rd_mem <= ~w_ctrl_space;
                if (w_ctrl_space) begin
                    r_hold <= w_ctrl_rdata;
                end else begin
                    r_mem_sel <= w_mem_sel;
                end
            end else begin
                r_rd_mem <= 1'b0;
            end
        end
    end

    assign wdata = r_rd_mem ? w_mem_slice : r_hold;

endmodule

`default_nettype wire

// File: tb/tb_xdata_ctrl.sv
// ============================================================================
//  Module      : tb_xdata_ctrl
//  Description : Directed self-checking bench for xdata_ctrl with a
//                synchronous-read memory model behind the memory strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xdata_ctrl;

    localparam int DATA_W     = 32;
    localparam int N_MEM      = 4;
    localparam int N_MEM_W    = 3;
    localparam int MEM_ADDR_W = 4;
    localparam int CONF_W     = 64;
    localparam int AW         = N_MEM_W + MEM_ADDR_W + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    valid;
    logic                    we;
    logic [AW-1:0]           addr;
    logic [DATA_W-1:0]       rdata;
    logic [DATA_W-1:0]       wdata;
    logic [N_MEM-1:0]        mem_valid;
    logic [MEM_ADDR_W-1:0]   mem_addr;
    logic [N_MEM*DATA_W-1:0] mem_rdata;
    logic [2*N_MEM-1:0]      fu_done;
    logic [CONF_W-1:0]       config_bus;
    logic [CONF_W-1:0]       config_shadow;
    logic                    run;
    logic                    busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int run_cnt = 0;
    int pulse_cyc[$];

    logic [DATA_W-1:0] ram [N_MEM][16];
    logic [DATA_W-1:0] q   [N_MEM];

    localparam logic [CONF_W-1:0] CFG_X = 64'h0123_4567_89AB_CDEF;
    localparam logic [CONF_W-1:0] CFG_Y = 64'hFEDC_BA98_7654_3210;

    xdata_ctrl #(
        .DATA_W     (DATA_W),
        .N_MEM      (N_MEM),
        .N_MEM_W    (N_MEM_W),
        .MEM_ADDR_W (MEM_ADDR_W),
        .CONF_W     (CONF_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid         (valid),
        .we            (we),
        .addr          (addr),
        .rdata         (rdata),
        .wdata         (wdata),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .fu_done       (fu_done),
        .config_bus    (config_bus),
        .config_shadow (config_shadow),
        .run           (run),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every run pulse with the cycle number it appeared in
    always @(negedge clk) begin
        if (run === 1'b1) begin
            run_cnt++;
            pulse_cyc.push_back(cyc);
        end
    end

    // Synchronous-read memory model
    always @(posedge clk) begin
        for (int j = 0; j < N_MEM; j++) begin
            if (mem_valid[j] === 1'b1) begin
                if (we) ram[j][mem_addr] <= rdata;
                else    q[j] <= ram[j][mem_addr];
            end
        end
    end

    assign mem_rdata = {q[3], q[2], q[1], q[0]};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] maddr(input int sel, input int word);
        logic [N_MEM_W-1:0]    s;
        logic [MEM_ADDR_W-1:0] w;
        s = N_MEM_W'(sel);
        w = MEM_ADDR_W'(word);
        return {1'b0, s, w};
    endfunction

    function automatic logic [AW-1:0] caddr(input int r);
        logic [1:0] rr;
        rr = 2'(r);
        return {1'b1, {(AW-3){1'b0}}, rr};
    endfunction

    task automatic host_wr(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        valid = 1'b1; we = 1'b1; addr = a; rdata = d;
        tick();
        valid = 1'b0; we = 1'b0; addr = '0; rdata = '0;
    endtask

    task automatic host_rd(input logic [AW-1:0] a);
        valid = 1'b1; we = 1'b0; addr = a;
        tick();
        valid = 1'b0; addr = '0;
    endtask

    initial begin
        int n;
        int k;
        for (int j = 0; j < N_MEM; j++) begin
            q[j] = '0;
            for (int w = 0; w < 16; w++) ram[j][w] = '0;
        end
        rst = 1'b1; valid = 1'b0; we = 1'b0; addr = '0; rdata = '0;
        fu_done = '0; config_bus = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_run", 64'(run), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_shadow", config_shadow, 64'd0);
        rst = 1'b0;
        tick();
        host_rd(caddr(1));
        check("rst_status", 64'(wdata), 64'd0);

        // ---------------- memory write/read ----------------
        valid = 1'b1; we = 1'b1; addr = maddr(2, 5); rdata = 32'hDEADBEEF;
        #1;
        check("wr_mem_valid", 64'(mem_valid), 64'b0100);
        check("wr_mem_addr", 64'(mem_addr), 64'd5);
        tick();
        valid = 1'b1; we = 1'b0; addr = maddr(2, 5); rdata = '0;
        #1;
        check("rd_mem_valid", 64'(mem_valid), 64'b0100);
        tick();
        valid = 1'b0; addr = '0;
        check("rd_wdata", 64'(wdata), 64'hDEADBEEF);
        tick();
        check("rd_hold", 64'(wdata), 64'hDEADBEEF);

        host_wr(maddr(0, 3), 32'h12345678);
        host_rd(maddr(0, 3));
        check("rd_mem0", 64'(wdata), 64'h12345678);

        // Out-of-range memory select
        valid = 1'b1; we = 1'b0; addr = maddr(5, 0);
        #1;
        check("oor_mem_valid", 64'(mem_valid), 64'd0);
        tick();
        valid = 1'b0; addr = '0;
        check("oor_wdata", 64'(wdata), 64'd0);

        // ---------------- single run, config freeze ----------------
        config_bus = CFG_X;
        fu_done = '0;
        n = run_cnt;
        host_wr(caddr(0), 32'h1);
        check("start_busy_load", 64'(busy), 64'd1);
        check("start_run_load", 64'(run), 64'd0);
        tick();
        check("fire_run", 64'(run), 64'd1);
        check("fire_shadow", config_shadow, CFG_X);
        config_bus = CFG_Y;
        tick();
        check("wait_run", 64'(run), 64'd0);
        tick(); tick();
        check("wait_busy", 64'(busy), 64'd1);
        check("wait_shadow", config_shadow, CFG_X);
        fu_done = '1;
        tick();
        check("done_busy", 64'(busy), 64'd0);
        check("single_pulse", 64'(run_cnt - n), 64'd1);
        check("done_shadow", config_shadow, CFG_X);
        host_rd(caddr(1));
        check("done_status", 64'(wdata), 64'b010);

        // ---------------- guard window with done already high ----------------
        n = run_cnt;
        host_wr(caddr(0), 32'h1);
        tick(); tick(); tick();
        check("guard_busy", 64'(busy), 64'd1);
        tick();
        check("guard_idle", 64'(busy), 64'd0);
        check("guard_pulse", 64'(run_cnt - n), 64'd1);

        // ---------------- start while busy, err clear, abort in WAIT --------
        fu_done = '0;
        host_wr(caddr(0), 32'h1);
        tick(); tick();
        n = run_cnt;
        host_wr(caddr(0), 32'h1);
        tick(); tick(); tick();
        check("busy_start_nopulse", 64'(run_cnt - n), 64'd0);
        host_rd(caddr(1));
        check("err_status", 64'(wdata), 64'b101);
        host_wr(caddr(1), 32'h4);
        host_rd(caddr(1));
        check("err_clear", 64'(wdata), 64'b001);
        host_wr(caddr(0), 32'h2);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_run", 64'(run), 64'd0);
        n = run_cnt;
        tick(); tick(); tick();
        check("abort_nopulse", 64'(run_cnt - n), 64'd0);
        host_rd(caddr(1));
        check("abort_status", 64'(wdata), 64'd0);

        // ---------------- reset while in FIRE ----------------
        host_wr(caddr(0), 32'h1);
        tick();
        check("rfire_run", 64'(run), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rfire_busy", 64'(busy), 64'd0);
        check("rfire_run_after", 64'(run), 64'd0);
        check("rfire_shadow", config_shadow, 64'd0);
        n = run_cnt;
        tick(); tick(); tick();
        check("rfire_nopulse", 64'(run_cnt - n), 64'd0);
        host_rd(caddr(1));
        check("rfire_status", 64'(wdata), 64'd0);

        // Abort and start in one write acts as abort
        n = run_cnt;
        host_wr(caddr(0), 32'h3);
        check("abst_busy", 64'(busy), 64'd0);
        tick(); tick();
        check("abst_nopulse", 64'(run_cnt - n), 64'd0);

        // ---------------- repeat runs ----------------
        fu_done = '1;
        host_wr(caddr(2), 32'h2);
        host_rd(caddr(2));
`ifdef XDATA_CTRL_REPEAT_EN
        check("rc_read", 64'(wdata), 64'd2);
`else
        check("rc_read", 64'(wdata), 64'd0);
`endif
        pulse_cyc.delete();
        host_wr(caddr(0), 32'h1);
        host_wr(caddr(2), 32'h7);
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("rep_timeout", 64'(k < 40), 64'd1);
        tick();
        check("rep_busy", 64'(busy), 64'd0);
`ifdef XDATA_CTRL_REPEAT_EN
        check("rep_pulses", 64'(pulse_cyc.size()), 64'd3);
        if (pulse_cyc.size() == 3) begin
            check("rep_gap1", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd3);
            check("rep_gap2", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'd3);
        end
`else
        check("rep_pulses", 64'(pulse_cyc.size()), 64'd1);
`endif
        host_rd(caddr(1));
        check("rep_status", 64'(wdata), 64'b010);
        host_rd(caddr(2));
`ifdef XDATA_CTRL_REPEAT_EN
        check("rc_busy_wr", 64'(wdata), 64'd2);
`else
        check("rc_busy_wr", 64'(wdata), 64'd0);
`endif
        host_rd(caddr(3));
        check("reserved_read", 64'(wdata), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
